// File: rtl/pc_sequencer.sv
// Multi-cycle PC/fetch controller: fetches over a req/ready handshake, waits for execute,
// then commits pc_next. Flags misaligned targets and fetch timeouts; supports halt.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [15:0] FETCH_TIMEOUT = 16'd256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [31:0] pc_next,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        HALTED = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] tmo_cnt;

    // Handshake/status outputs are pure decodes of the registered state.
    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALTED);
    assign fault       = (state == FAULT);
    assign imem_addr   = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instret     <= 32'd0;
            fault_cause <= 2'b00;
            fault_addr  <= 32'd0;
            tmo_cnt     <= 16'd0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    // A same-cycle ready takes priority over the timeout.
                    if (imem_ready) begin
                        instr   <= imem_rdata;
                        tmo_cnt <= 16'd0;
                        state   <= EXEC;
                    end else if (FETCH_TIMEOUT != 16'd0 &&
                                 tmo_cnt == FETCH_TIMEOUT - 16'd1) begin
                        fault_cause <= 2'b10;
                        fault_addr  <= pc;
                        state       <= FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        if (pc_next[1:0] != 2'b00) begin
                            fault_cause <= 2'b01;
                            fault_addr  <= pc_next;
                            state       <= FAULT;
                        end else begin
                            pc      <= pc_next;
                            instret <= instret + 32'd1;
                            state   <= halt ? HALTED : FETCH;
                        end
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule
